// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/acknowledge port of the load/store unit
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit: decode, lane align, one memory transaction
module load_store_unit (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               inst,
    input  logic [31:0]               addr,
    input  logic [31:0]               store_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [31:0]               load_data,
    load_store_unit_if.master         mem
);
    typedef enum logic {IDLE, REQ} state_t;

    state_t      state, state_n;
    logic        done_n, err_n;
    logic [31:0] load_data_n;
    logic        we_q, we_n;
    logic [31:0] maddr_q, maddr_n;
    logic [31:0] wdata_q, wdata_n;
    logic [3:0]  wmask_q, wmask_n;
    logic [2:0]  f3_q, f3_n;
    logic [1:0]  off_q, off_n;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, legal, aligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic [31:0] sh;
    logic [31:0] ld_ext;
    logic        unused_inst;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign unused_inst = ^{inst[31:15], inst[11:7]};
    assign is_load     = (opcode == 7'b0000011);
    assign is_store    = (opcode == 7'b0100011);

    always_comb begin
        legal = 1'b0;
        if (is_load)
            legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        else if (is_store)
            legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    end

    // funct3[1:0] encodes the access size for both loads and stores
    assign aligned = !((funct3[1:0] == 2'b01 && addr[0]) ||
                       (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00));

    always_comb begin
        st_wdata = store_data;
        st_wmask = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wmask = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wmask = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = store_data;
                st_wmask = 4'b1111;
            end
        endcase
    end

    assign sh = mem.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_ext = {24'h0, sh[7:0]};
            3'b001:  ld_ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ld_ext = {16'h0, sh[15:0]};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        state_n     = state;
        done_n      = 1'b0;
        err_n       = 1'b0;
        load_data_n = load_data;
        we_n        = we_q;
        maddr_n     = maddr_q;
        wdata_n     = wdata_q;
        wmask_n     = wmask_q;
        f3_n        = f3_q;
        off_n       = off_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (legal && aligned) begin
                        state_n = REQ;
                        f3_n    = funct3;
                        off_n   = addr[1:0];
                        we_n    = is_store;
                        maddr_n = {addr[31:2], 2'b00};
                        wdata_n = st_wdata;
                        wmask_n = is_store ? st_wmask : 4'b0000;
                    end else begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    if (!we_q)
                        load_data_n = ld_ext;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // async reset drops mem_req (derived from state) without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'h0;
            we_q      <= 1'b0;
            maddr_q   <= 32'h0;
            wdata_q   <= 32'h0;
            wmask_q   <= 4'h0;
            f3_q      <= 3'h0;
            off_q     <= 2'h0;
        end else begin
            state     <= state_n;
            done      <= done_n;
            err       <= err_n;
            load_data <= load_data_n;
            we_q      <= we_n;
            maddr_q   <= maddr_n;
            wdata_q   <= wdata_n;
            wmask_q   <= wmask_n;
            f3_q      <= f3_n;
            off_q     <= off_n;
        end
    end

    assign busy          = (state == REQ);
    assign mem.mem_req   = (state == REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wmask = wmask_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] inst = 32'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        busy, done, err;
    logic [31:0] load_data;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;

    load_store_unit_if mem_if ();

    load_store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .inst       (inst),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem        (mem_if.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd);
        inst       = {17'h0, f3, 5'h0, op};
        addr       = a;
        store_data = sd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic we, input logic [31:0] ma,
                             input logic [31:0] wd, input logic [3:0] wm);
        chk({tag, ".req"},   {31'h0, mem_if.mem_req}, 32'h1);
        chk({tag, ".busy"},  {31'h0, busy}, 32'h1);
        chk({tag, ".we"},    {31'h0, mem_if.mem_we}, {31'h0, we});
        chk({tag, ".addr"},  mem_if.mem_addr, ma);
        chk({tag, ".wdata"}, mem_if.mem_wdata, wd);
        chk({tag, ".wmask"}, {28'h0, mem_if.mem_wmask}, {28'h0, wm});
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = rd;
        tick();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
    endtask

    task automatic check_done(input string tag, input logic e, input logic [31:0] ld);
        chk({tag, ".done"}, {31'h0, done}, 32'h1);
        chk({tag, ".err"},  {31'h0, err}, {31'h0, e});
        chk({tag, ".req0"}, {31'h0, mem_if.mem_req}, 32'h0);
        chk({tag, ".busy0"}, {31'h0, busy}, 32'h0);
        chk({tag, ".ld"},   load_data, ld);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rd, input logic [31:0] exp_ld);
        issue(OP_LD, f3, a, 32'h0);
        check_req(tag, 1'b0, {a[31:2], 2'b00}, mem_if.mem_wdata, 4'b0000);
        ack(rd);
        check_done(tag, 1'b0, exp_ld);
        tick();
    endtask

    task automatic bad(input string tag, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] keep_ld);
        issue(op, f3, a, 32'h0);
        check_done(tag, 1'b1, keep_ld);
        tick();
        chk({tag, ".idle_req"}, {31'h0, mem_if.mem_req}, 32'h0);
        chk({tag, ".done_clr"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        tick();
        tick();
        chk("rst.busy",  {31'h0, busy}, 32'h0);
        chk("rst.done",  {31'h0, done}, 32'h0);
        chk("rst.req",   {31'h0, mem_if.mem_req}, 32'h0);
        chk("rst.addr",  mem_if.mem_addr, 32'h0);
        chk("rst.wmask", {28'h0, mem_if.mem_wmask}, 32'h0);
        chk("rst.ld",    load_data, 32'h0);
        reset = 1'b0;
        tick();

        // SW with ack delayed 3 cycles; outputs must stay stable while waiting
        issue(OP_ST, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            check_req("sw", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
            chk("sw.nodone", {31'h0, done}, 32'h0);
            tick();
        end
        check_req("sw.k", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111);
        ack(32'h0);
        check_done("sw", 1'b0, 32'h0);
        tick();

        issue(OP_ST, 3'b000, 32'h0000_1002, 32'h0000_00A5);
        check_req("sb", 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'b0100);
        ack(32'h0);
        check_done("sb", 1'b0, 32'h0);
        tick();

        issue(OP_ST, 3'b001, 32'h0000_1002, 32'h0000_1234);
        check_req("sh", 1'b1, 32'h0000_1000, 32'h1234_1234, 4'b1100);
        ack(32'h0);
        check_done("sh", 1'b0, 32'h0);
        tick();

        load("lb0",  3'b000, 32'h0000_1000, 32'h80F0_7F81, 32'hFFFF_FF81);
        load("lbu0", 3'b100, 32'h0000_1000, 32'h80F0_7F81, 32'h0000_0081);
        load("lb1",  3'b000, 32'h0000_1001, 32'h80F0_7F81, 32'h0000_007F);
        load("lh2",  3'b001, 32'h0000_1002, 32'h80F0_7F81, 32'hFFFF_80F0);
        load("lhu2", 3'b101, 32'h0000_1002, 32'h80F0_7F81, 32'h0000_80F0);
        load("lw",   3'b010, 32'h0000_1000, 32'h80F0_7F81, 32'h80F0_7F81);

        bad("lw_mis",  OP_LD, 3'b010, 32'h0000_1002, 32'h80F0_7F81);
        bad("lh_mis",  OP_LD, 3'b001, 32'h0000_1001, 32'h80F0_7F81);
        bad("ld_f011", OP_LD, 3'b011, 32'h0000_1000, 32'h80F0_7F81);
        bad("st_f100", OP_ST, 3'b100, 32'h0000_1000, 32'h80F0_7F81);
        bad("bad_op",  7'b0110011, 3'b000, 32'h0000_1000, 32'h80F0_7F81);

        // start during REQ must not disturb the pending access
        issue(OP_LD, 3'b010, 32'h0000_2000, 32'h0);
        inst  = {17'h0, 3'b010, 5'h0, OP_ST};
        addr  = 32'h0000_3000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_req("ign", 1'b0, 32'h0000_2000, mem_if.mem_wdata, 4'b0000);
        ack(32'h1111_2222);
        check_done("ign", 1'b0, 32'h1111_2222);
        tick();
        chk("ign.noreq", {31'h0, mem_if.mem_req}, 32'h0);

        // start in the done cycle is accepted
        issue(OP_ST, 3'b010, 32'h0000_4000, 32'hCAFE_F00D);
        ack(32'h0);
        check_done("chain1", 1'b0, 32'h1111_2222);
        issue(OP_LD, 3'b000, 32'h0000_5003, 32'h0);
        check_req("chain2", 1'b0, 32'h0000_5000, mem_if.mem_wdata, 4'b0000);
        ack(32'h7F00_0000);
        check_done("chain2", 1'b0, 32'h0000_007F);
        tick();

        // reset mid-REQ: mem_req drops with no clock edge, done never pulses
        issue(OP_ST, 3'b010, 32'h0000_6000, 32'h5555_AAAA);
        check_req("rstmid", 1'b1, 32'h0000_6000, 32'h5555_AAAA, 4'b1111);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.req",   {31'h0, mem_if.mem_req}, 32'h0);
        chk("rstmid.busy",  {31'h0, busy}, 32'h0);
        chk("rstmid.we",    {31'h0, mem_if.mem_we}, 32'h0);
        chk("rstmid.addr",  mem_if.mem_addr, 32'h0);
        chk("rstmid.wdata", mem_if.mem_wdata, 32'h0);
        chk("rstmid.wmask", {28'h0, mem_if.mem_wmask}, 32'h0);
        chk("rstmid.ld",    load_data, 32'h0);
        tick();
        reset = 1'b0;
        mem_if.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rstmid.nodone", {31'h0, done}, 32'h0);
        end
        mem_if.mem_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit sitting directly downstream of the ALU in the execute stage. Takes the ALU's effective-address result, the decoded instruction and the rs2 value, and runs one request/acknowledge transaction on the data-memory port. Lane-aligns and masks store data, and extracts and sign/zero-extends load data. Flags misaligned or illegal accesses without touching memory.

## Interface
- No parameters; datapath is fixed at 32 bits, 4 byte lanes.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe, sampled only in IDLE.
- inst  in  32  instruction; uses [6:0] opcode and [14:12] funct3.
- addr  in  32  effective address (ALU result, rs1 + imm).
- store_data  in  32  rs2 value; only the low byte/half is used for SB/SH.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion pulse, for success or error.
- err  out  1  valid with done; 1 means misaligned or illegal, and no memory access was made.
- load_data  out  32  extended load result; holds its value until the next successful load.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 for store, 0 for load; stable while mem_req is high.
- mem_addr  out  32  word address {addr[31:2],2'b00}; stable while mem_req is high.
- mem_wdata  out  32  lane-replicated store data.
- mem_wmask  out  4  byte-lane enables; 4'b0000 for loads.
- mem_rdata  in  32  read word, valid in the cycle mem_ack is high.
- mem_ack  in  1  transfer complete, sampled while mem_req is high.

## Operation
- States: IDLE, REQ. All outputs are registered.
- Opcodes: 7'b0000011 is a load, 7'b0100011 is a store. Any other opcode is illegal.
- funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. 011, 110 and 111 are illegal.
- funct3 for stores: 000 SB, 001 SH, 010 SW. 011 through 111 are illegal.
- Misaligned access: a halfword with addr[0]=1, or a word with addr[1:0]!=0.
- IDLE, start, legal and aligned:
  - latch funct3, addr[1:0] and the load/store flag;
  - drive mem_addr, mem_we, mem_wdata and mem_wmask;
  - set mem_req=1 and go to REQ.
- IDLE, start, illegal or misaligned: next cycle done=1 and err=1. Stay in IDLE, mem_req stays 0, load_data is unchanged.
- REQ, mem_ack=0: hold every mem_* output stable.
- REQ, mem_ack=1: the next cycle has mem_req=0, done=1, err=0 and state IDLE.
  - Load: load_data is updated in that same cycle.
  - Store: load_data is unchanged.
- start is ignored while in REQ; there is no queueing.
- start asserted in the done cycle is accepted, because the state is already IDLE.
- Store lane rules:
  - SB: wdata={4{sd[7:0]}}, wmask=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wmask=addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata=sd, wmask=4'b1111.
- Load extraction:
  - Form sh=mem_rdata>>(8*addr[1:0]).
  - LB/LBU take sh[7:0], sign- or zero-extended to 32 bits.
  - LH/LHU take sh[15:0], sign- or zero-extended.
  - LW takes mem_rdata as-is.

## Timing
- Reset values: state IDLE, busy=0, done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, load_data=0.
- Reset asserted mid-REQ forces mem_req low immediately, with no clock needed. The transaction is abandoned and done is never raised.
- Start sampled in cycle 0 gives mem_req=1 in cycle 1.
- mem_ack at cycle k (k≥1) gives done in cycle k+1.
- Minimum latency is 2 cycles, start to done, when mem_ack is high in cycle 1.
- Error path latency is 1 cycle, start to done.
- busy is high from cycle 1 through cycle k, and low in the done cycle.
- Back-to-back throughput is one access per k+1 cycles.

## Test plan
- SW, addr=0x0000_1004, sd=0xDEAD_BEEF, ack delayed 3 cycles:
  - mem_addr=0x1004, wmask=4'b1111, wdata=0xDEADBEEF, mem_we=1;
  - outputs stable for 3 cycles; done, err=0 one cycle after ack.
- SB, addr=0x1002, sd=0x0000_00A5: wdata=0xA5A5A5A5, wmask=4'b0100.
- SH, addr=0x1002, sd=0x1234: wmask=4'b1100.
- Loads, mem_rdata=0x80F0_7F81:
  - LB, addr=0x1000 → 0xFFFFFF81; LBU, same addr → 0x00000081;
  - LB, addr=0x1001 → 0x0000007F;
  - LH, addr=0x1002 → 0xFFFF80F0; LHU, same addr → 0x000080F0;
  - LW → 0x80F07F81.
- Error path, no mem_req in any case:
  - LW at 0x1002 → done=err=1 in 1 cycle;
  - LH at 0x1001 → done=err=1;
  - load funct3=011 → done=err=1;
  - load_data keeps its previous value.
- Robustness:
  - start pulsed during REQ → ignored;
  - start in the done cycle → accepted, mem_req high the next cycle;
  - reset raised mid-REQ → mem_req drops at once, all outputs return to reset values, done never pulses.
